multi_collision_controller: RTL and testbench

MULTI_COLLISION_CONTROLLER -- requirements
Module: multi_collision_controller

---
 rtl/multi_collision_controller.sv | 140 ++++++++++++++
 tb/tb_multi_collision_controller.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/multi_collision_controller.sv
`default_nettype none
// ============================================================================
// Module      : multi_collision_controller
// Description : Primary-object (ball) collision detector with per-frame hit
//               pulses, frame hit mask and saturating hit counter. Optional
//               per-channel frame holdoff when COLLISION_HOLDOFF_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module multi_collision_controller #(
    parameter int N_OBJ          = 4,
    parameter int CNT_W          = 8,
    parameter int MODE           = 0,
    parameter int HOLDOFF_FRAMES = 2
) (
    input  logic               clk,
    input  logic               resetN,
    input  logic               startOfFrame,
    input  logic [N_OBJ-1:0]   drawing_request,
    input  logic               clear_hits,
    output logic [N_OBJ-2:0]   collision,
    output logic [N_OBJ-2:0]   hit_pulse,
    output logic [N_OBJ-2:0]   frame_hits,
    output logic               frame_valid,
    output logic [CNT_W-1:0]   total_hits
);

    localparam int c_NCH  = N_OBJ - 1;
    localparam int c_PC_W = 4;

    if (N_OBJ < 2 || N_OBJ > 8 || MODE < 0 || MODE > 1 || CNT_W < 1 ||
        HOLDOFF_FRAMES < 1 || HOLDOFF_FRAMES > 15) begin : g_param_check
        $error("multi_collision_controller: illegal parameter value");
    end

    logic [c_NCH-1:0] w_blocked;
    logic [c_NCH-1:0] w_pulse;
    logic [c_NCH-1:0] r_hit;
    logic [c_NCH-1:0] r_acc;
    logic [c_NCH-1:0] r_frame_hits;
    logic             r_frame_valid;
    logic [CNT_W-1:0] r_total;

    assign collision = {c_NCH{drawing_request[0]}} & drawing_request[N_OBJ-1:1];

    // Flags are cleared combinationally on startOfFrame so an overlap in that
    // cycle is judged against the new frame. A held-off overlap still marks the
    // flag: the frame's first contact is consumed even when its pulse is muted.
    if (MODE == 0) begin : g_mode_per_channel
        logic [c_NCH-1:0] r_flag;
        logic [c_NCH-1:0] w_flag_eff;

        assign w_flag_eff = startOfFrame ? '0 : r_flag;
        assign w_pulse    = collision & ~w_flag_eff & ~w_blocked;

        always_ff @(posedge clk or negedge resetN) begin
            if (!resetN) r_flag <= '0;
            else         r_flag <= w_flag_eff | collision;
        end
    end else begin : g_mode_shared
        logic             r_flag;
        logic             w_flag_eff;
        logic [c_NCH-1:0] w_cand;

        assign w_flag_eff = startOfFrame ? 1'b0 : r_flag;
        assign w_cand     = (w_flag_eff ? '0 : collision) & ~w_blocked;
        // Isolate the lowest set bit so only one channel wins per frame.
        assign w_pulse    = w_cand & (-w_cand);

        always_ff @(posedge clk or negedge resetN) begin
            if (!resetN) r_flag <= 1'b0;
            else         r_flag <= w_flag_eff | (|collision);
        end
    end

`ifdef COLLISION_HOLDOFF_EN
    localparam logic [3:0] c_HOLD_LOAD = 4'(HOLDOFF_FRAMES);
    logic [c_NCH-1:0] w_load;

    assign w_load = (MODE == 1) ? {c_NCH{|w_pulse}} : w_pulse;

    for (genvar k = 0; k < c_NCH; k++) begin : g_holdoff
        logic [3:0] r_cnt;

        assign w_blocked[k] = (r_cnt != 4'd0);

        always_ff @(posedge clk or negedge resetN) begin
            if (!resetN)                         r_cnt <= 4'd0;
            else if (w_load[k])                  r_cnt <= c_HOLD_LOAD;
            else if (startOfFrame && w_blocked[k]) r_cnt <= r_cnt - 4'd1;
        end
    end
`else
    assign w_blocked = '0;
`endif

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_hit         <= '0;
            r_acc         <= '0;
            r_frame_hits  <= '0;
            r_frame_valid <= 1'b0;
        end else begin
            r_hit         <= w_pulse;
            r_frame_valid <= startOfFrame;
            if (startOfFrame) begin
                r_frame_hits <= r_acc;
                r_acc        <= w_pulse;
            end else begin
                r_acc        <= r_acc | w_pulse;
            end
        end
    end

    logic [c_PC_W-1:0]       w_popcnt;
    logic [CNT_W+c_PC_W-1:0] w_sum;
    logic [CNT_W-1:0]        w_total_next;

    always_comb begin
        w_popcnt = '0;
        for (int i = 0; i < c_NCH; i++) begin
            w_popcnt = w_popcnt + c_PC_W'(r_hit[i]);
        end
    end

    assign w_sum        = {{c_PC_W{1'b0}}, r_total} + {{CNT_W{1'b0}}, w_popcnt};
    assign w_total_next = (w_sum[CNT_W+c_PC_W-1:CNT_W] != '0) ? '1 : w_sum[CNT_W-1:0];

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN)         r_total <= '0;
        else if (clear_hits) r_total <= '0;
        else                 r_total <= w_total_next;
    end

    assign hit_pulse   = r_hit;
    assign frame_hits  = r_frame_hits;
    assign frame_valid = r_frame_valid;
    assign total_hits  = r_total;

endmodule
`default_nettype wire

// File: tb/tb_multi_collision_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_multi_collision_controller
// Description : Scoreboard bench for multi_collision_controller (MODE 0 with
//               CNT_W=4, and MODE 1). Holdoff scenario when COLLISION_HOLDOFF_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multi_collision_controller;

    logic       clk = 1'b0;
    logic       resetN, sof, clr;
    logic [3:0] dr0, dr1;

    logic [2:0] col0, hp0, fh0, col1, hp1, fh1;
    logic       fv0, fv1;
    logic [3:0] th0;
    logic [7:0] th1;

    int n_tests = 0;
    int n_fail  = 0;

    logic [2:0] q_hit0[$];
    logic [2:0] q_hit1[$];
    logic [2:0] q_frame0[$];

    always #5 clk = ~clk;

    multi_collision_controller #(.N_OBJ(4), .CNT_W(4), .MODE(0), .HOLDOFF_FRAMES(2)) dut0 (
        .clk(clk), .resetN(resetN), .startOfFrame(sof), .drawing_request(dr0),
        .clear_hits(clr), .collision(col0), .hit_pulse(hp0), .frame_hits(fh0),
        .frame_valid(fv0), .total_hits(th0));

    multi_collision_controller #(.N_OBJ(4), .CNT_W(8), .MODE(1), .HOLDOFF_FRAMES(2)) dut1 (
        .clk(clk), .resetN(resetN), .startOfFrame(sof), .drawing_request(dr1),
        .clear_hits(clr), .collision(col1), .hit_pulse(hp1), .frame_hits(fh1),
        .frame_valid(fv1), .total_hits(th1));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: consumes expectations whenever the DUT presents a pulse.
    always @(negedge clk) begin
        if (hp0 != 3'b000) begin
            if (q_hit0.size() == 0) check("hit0_unexpected", 32'(hp0), 32'd0);
            else                    check("hit0", 32'(hp0), 32'(q_hit0.pop_front()));
        end
        if (hp1 != 3'b000) begin
            if (q_hit1.size() == 0) check("hit1_unexpected", 32'(hp1), 32'd0);
            else                    check("hit1", 32'(hp1), 32'(q_hit1.pop_front()));
        end
        if (fv0) begin
            if (q_frame0.size() == 0) check("frame0_unexpected", 32'(fh0), 32'hFFFF);
            else                      check("frame0", 32'(fh0), 32'(q_frame0.pop_front()));
        end
    end

    task automatic drive(input logic s, input logic [3:0] a, input logic [3:0] b, input logic c);
        sof = s; dr0 = a; dr1 = b; clr = c;
        @(posedge clk); #1;
    endtask

    task automatic frame_start(input logic [2:0] exp_fh, input logic [3:0] a, input logic [3:0] b);
        q_frame0.push_back(exp_fh);
        drive(1'b1, a, b, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        resetN = 1'b0; sof = 1'b0; clr = 1'b0; dr0 = 4'b0101; dr1 = 4'b0000;
        repeat (3) @(posedge clk);
        #1;
        check("rst_hit_pulse",   32'(hp0), 32'd0);
        check("rst_frame_hits",  32'(fh0), 32'd0);
        check("rst_frame_valid", 32'(fv0), 32'd0);
        check("rst_total_hits",  32'(th0), 32'd0);
        check("rst_collision",   32'(col0), 32'b010);
        dr0 = 4'b0000;
        resetN = 1'b1;

`ifdef COLLISION_HOLDOFF_EN
        // Continuous overlap on channel 0: pulses at the SOF of frames 0, 3, 6.
        for (int f = 0; f < 7; f++) begin
            q_frame0.push_back((f > 0 && (f - 1) % 3 == 0) ? 3'b001 : 3'b000);
            if (f % 3 == 0) q_hit0.push_back(3'b001);
            drive(1'b1, 4'b0011, 4'b0000, 1'b0);
            check("holdoff_sof_pulse", 32'(hp0), (f % 3 == 0) ? 32'd1 : 32'd0);
            for (int c = 0; c < 3; c++) drive(1'b0, 4'b0011, 4'b0000, 1'b0);
            check("holdoff_collision", 32'(col0), 32'b001);
        end
        check("holdoff_total", 32'(th0), 32'd3);
        resetN = 1'b0; #1;
        check("mid_rst_hit",   32'(hp0), 32'd0);
        check("mid_rst_total", 32'(th0), 32'd0);
        check("mid_rst_fv",    32'(fv0), 32'd0);
        drive(1'b0, 4'b0011, 4'b0000, 1'b0);
        drive(1'b0, 4'b0011, 4'b0000, 1'b0);
        check("mid_rst_held",  32'(hp0), 32'd0);
        resetN = 1'b1;
        q_hit0.push_back(3'b001);
        drive(1'b0, 4'b0011, 4'b0000, 1'b0);
        check("post_rst_pulse", 32'(hp0), 32'd1);
        drive(1'b0, 4'b0000, 4'b0000, 1'b0);
`else
        // Single channel overlap held for 10 cycles: one pulse, one cycle late.
        frame_start(3'b000, 4'b0000, 4'b0000);
        drive(1'b0, 4'b0000, 4'b0000, 1'b0);
        for (int i = 0; i < 10; i++) begin
            if (i == 0) q_hit0.push_back(3'b001);
            drive(1'b0, 4'b0011, 4'b0000, 1'b0);
            check("held_collision", 32'(col0), 32'b001);
            check("held_hit_once",  32'(hp0), (i == 0) ? 32'd1 : 32'd0);
        end
        drive(1'b0, 4'b0000, 4'b0000, 1'b0);
        check("total_after_one", 32'(th0), 32'd1);

        // Channels 0 and 2 together.
        frame_start(3'b001, 4'b0000, 4'b0000);
        check("fv_pulse",  32'(fv0), 32'd1);
        check("fh_single", 32'(fh0), 32'b001);
        drive(1'b0, 4'b0000, 4'b0000, 1'b0);
        check("fv_one_cycle", 32'(fv0), 32'd0);
        q_hit0.push_back(3'b101);
        drive(1'b0, 4'b1011, 4'b0000, 1'b0);
        check("dual_collision", 32'(col0), 32'b101);
        check("dual_hit",       32'(hp0), 32'b101);
        drive(1'b0, 4'b1011, 4'b0000, 1'b0);
        check("dual_no_repeat", 32'(hp0), 32'd0);
        drive(1'b0, 4'b0000, 4'b0000, 1'b0);
        check("total_plus_two", 32'(th0), 32'd3);
        frame_start(3'b101, 4'b0000, 4'b0000);
        check("fh_dual", 32'(fh0), 32'b101);

        // Overlap in the SOF cycle after a hit in the previous frame.
        q_hit0.push_back(3'b010);
        drive(1'b0, 4'b0101, 4'b0000, 1'b0);
        drive(1'b0, 4'b0000, 4'b0000, 1'b0);
        q_hit0.push_back(3'b010);
        frame_start(3'b010, 4'b0101, 4'b0000);
        check("sof_hit", 32'(hp0), 32'b010);
        drive(1'b0, 4'b0101, 4'b0000, 1'b0);
        check("sof_hit_once", 32'(hp0), 32'd0);
        drive(1'b0, 4'b0000, 4'b0000, 1'b0);
        frame_start(3'b010, 4'b0000, 4'b0000);
        check("sof_hit_next_frame", 32'(fh0), 32'b010);

        // Saturation of the 4-bit counter, starting from 5.
        for (int j = 0; j < 20; j++) begin
            frame_start((j == 0) ? 3'b000 : 3'b001, 4'b0000, 4'b0000);
            q_hit0.push_back(3'b001);
            drive(1'b0, 4'b0011, 4'b0000, 1'b0);
            drive(1'b0, 4'b0000, 4'b0000, 1'b0);
            if (j == 8) check("total_14", 32'(th0), 32'd14);
        end
        check("total_saturated", 32'(th0), 32'd15);
        frame_start(3'b001, 4'b0000, 4'b0000);
        q_hit0.push_back(3'b001);
        drive(1'b0, 4'b0011, 4'b0000, 1'b0);
        drive(1'b0, 4'b0000, 4'b0000, 1'b1);
        check("clear_priority", 32'(th0), 32'd0);
        drive(1'b0, 4'b0000, 4'b0000, 1'b0);
        check("clear_stays", 32'(th0), 32'd0);

        // MODE 1: shared flag, lowest channel wins.
        frame_start(3'b001, 4'b0000, 4'b0000);
        q_hit1.push_back(3'b010);
        drive(1'b0, 4'b0000, 4'b1101, 1'b0);
        check("m1_collision", 32'(col1), 32'b110);
        check("m1_lowest",    32'(hp1), 32'b010);
        drive(1'b0, 4'b0000, 4'b1101, 1'b0);
        check("m1_no_repeat", 32'(hp1), 32'd0);
        drive(1'b0, 4'b0000, 4'b0011, 1'b0);
        check("m1_shared_flag", 32'(hp1), 32'd0);
        drive(1'b0, 4'b0000, 4'b0000, 1'b0);
        frame_start(3'b000, 4'b0000, 4'b0000);
        q_hit1.push_back(3'b001);
        drive(1'b0, 4'b0000, 4'b0011, 1'b0);
        check("m1_next_frame", 32'(hp1), 32'b001);
        drive(1'b0, 4'b0000, 4'b0000, 1'b0);
        drive(1'b0, 4'b0000, 4'b0000, 1'b0);
        check("m1_total", 32'(th1), 32'd2);

        // Reset mid-frame while every output is non-zero.
        q_hit0.push_back(3'b001);
        drive(1'b0, 4'b0011, 4'b0000, 1'b0);
        drive(1'b0, 4'b0011, 4'b0000, 1'b0);
        drive(1'b1, 4'b0011, 4'b0000, 1'b0);
        resetN = 1'b0; #1;
        check("mid_rst_hit",   32'(hp0), 32'd0);
        check("mid_rst_fh",    32'(fh0), 32'd0);
        check("mid_rst_fv",    32'(fv0), 32'd0);
        check("mid_rst_total", 32'(th0), 32'd0);
        drive(1'b0, 4'b0011, 4'b0000, 1'b0);
        drive(1'b0, 4'b0011, 4'b0000, 1'b0);
        check("mid_rst_held", 32'(hp0), 32'd0);
        resetN = 1'b1;
        q_hit0.push_back(3'b001);
        drive(1'b0, 4'b0011, 4'b0000, 1'b0);
        check("post_rst_pulse", 32'(hp0), 32'd1);
        drive(1'b0, 4'b0000, 4'b0000, 1'b0);
`endif

        repeat (3) drive(1'b0, 4'b0000, 4'b0000, 1'b0);
        check("hit0_queue_drained",   32'(q_hit0.size()), 32'd0);
        check("hit1_queue_drained",   32'(q_hit1.size()), 32'd0);
        check("frame0_queue_drained", 32'(q_frame0.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
